// File: rtl/spi_regfile_burst.sv
// SPI target with a parametrised config/status register file, all four SPI modes,
// burst transfers with address auto-increment and per-register write strobes.
module spi_regfile_burst #(
    parameter int                   NUM_CFG     = 8,
    parameter int                   NUM_STATUS  = 8,
    parameter int                   REG_WIDTH   = 8,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [REG_WIDTH-1:0] CFG_RESET   = {REG_WIDTH{1'b0}}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       mode,
    input  logic                             spi_cs_n,
    input  logic                             spi_clk,
    input  logic                             spi_mosi,
    output logic                             spi_miso,
    output logic                             spi_miso_oe,
    output logic [NUM_CFG*REG_WIDTH-1:0]     config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_regs,
    output logic [NUM_CFG-1:0]               cfg_wr_strobe,
    output logic                             busy
);

    localparam int               FRAME_MAX = (REG_WIDTH > 8) ? REG_WIDTH : 8;
    localparam int               CNT_W     = $clog2(FRAME_MAX);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_WIDTH - 1);
    localparam logic [6:0]       ADDR_LAST = 7'(NUM_CFG + NUM_STATUS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_nx_s;

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] cpol_sync_r;
    logic [SYNC_STAGES-1:0] cpha_sync_r;
    logic                   sclk_prev_r;
    logic                   cs_prev_r;

    logic                   cs_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cpol_s;
    logic                   cpha_s;
    logic                   cs_fall_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   lead_s;
    logic                   trail_s;
    logic                   sample_s;
    logic                   shift_s;
    logic                   active_s;

    logic                   cpol_r;
    logic                   cpha_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [FRAME_MAX-2:0]   rx_sr_r;
    logic [REG_WIDTH-1:0]   tx_sr_r;
    logic [6:0]             addr_r;
    logic                   miso_r;
    logic [NUM_CFG-1:0]     wr_pend_r;
    logic [NUM_CFG-1:0]     strobe_r;
    logic [REG_WIDTH-1:0]   cfg_r [NUM_CFG];

    logic [7:0]             cmd_byte_s;
    logic [REG_WIDTH-1:0]   rx_data_s;
    logic [6:0]             addr_inc_s;
    logic [6:0]             rd_addr_s;
    logic [REG_WIDTH-1:0]   rd_val_s;
    logic                   wr_commit_s;
    logic [NUM_CFG-1:0]     wr_hot_s;

    assign cs_s   = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
    assign cpol_s = cpol_sync_r[SYNC_STAGES-1];
    assign cpha_s = cpha_sync_r[SYNC_STAGES-1];

    // Pad synchronisers plus the registered copies used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            cpol_sync_r <= {SYNC_STAGES{1'b0}};
            cpha_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            cs_prev_r   <= 1'b1;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
            cpol_sync_r <= {cpol_sync_r[SYNC_STAGES-2:0], mode[1]};
            cpha_sync_r <= {cpha_sync_r[SYNC_STAGES-2:0], mode[0]};
            sclk_prev_r <= sclk_s;
            cs_prev_r   <= cs_s;
        end
    end

    // Edge classification against the mode latched at CS assertion
    always_comb begin
        cs_fall_s = cs_prev_r & ~cs_s;
        rise_s    = sclk_s & ~sclk_prev_r;
        fall_s    = ~sclk_s & sclk_prev_r;
        lead_s    = cpol_r ? fall_s : rise_s;
        trail_s   = cpol_r ? rise_s : fall_s;
        sample_s  = cpha_r ? trail_s : lead_s;
        shift_s   = cpha_r ? lead_s : trail_s;
        active_s  = (state_r != ST_IDLE) & ~cs_s;
    end

    // Frame decode, address sequencing and read-data mux
    always_comb begin
        cmd_byte_s  = {rx_sr_r[6:0], mosi_s};
        rx_data_s   = {rx_sr_r[REG_WIDTH-2:0], mosi_s};
        if (addr_r == ADDR_LAST) begin
            addr_inc_s = 7'd0;
        end else begin
            addr_inc_s = addr_r + 7'd1;
        end
        if (state_r == ST_CMD) begin
            rd_addr_s = cmd_byte_s[6:0];
        end else begin
            rd_addr_s = addr_inc_s;
        end
        rd_val_s = {REG_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CFG; i++) begin
            rd_val_s |= {REG_WIDTH{rd_addr_s == 7'(i)}} & cfg_r[i];
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            rd_val_s |= {REG_WIDTH{rd_addr_s == 7'(NUM_CFG + i)}}
                        & status_regs[i*REG_WIDTH +: REG_WIDTH];
        end
        wr_commit_s = active_s & sample_s & (state_r == ST_WDATA) & (bit_cnt_r == DATA_LAST);
        for (int k = 0; k < NUM_CFG; k++) begin
            wr_hot_s[k] = wr_commit_s & (addr_r == 7'(k));
        end
    end

    // Transaction state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; CS deassertion overrides everything, including a coincident sample
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_nx_s = ST_CMD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (cs_s) begin
                    state_nx_s = ST_IDLE;
                end else if (sample_s && (bit_cnt_r == CMD_LAST)) begin
                    state_nx_s = cmd_byte_s[7] ? ST_WDATA : ST_RDATA;
                end else begin
                    state_nx_s = ST_CMD;
                end
            end
            ST_WDATA, ST_RDATA: begin
                if (cs_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Shift registers, register file writes, strobes and MISO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            bit_cnt_r <= {CNT_W{1'b0}};
            rx_sr_r   <= {(FRAME_MAX-1){1'b0}};
            tx_sr_r   <= {REG_WIDTH{1'b0}};
            addr_r    <= 7'd0;
            miso_r    <= 1'b0;
            wr_pend_r <= {NUM_CFG{1'b0}};
            strobe_r  <= {NUM_CFG{1'b0}};
            for (int k = 0; k < NUM_CFG; k++) begin
                cfg_r[k] <= CFG_RESET;
            end
        end else begin
            wr_pend_r <= wr_hot_s;
            strobe_r  <= wr_pend_r;
            for (int k = 0; k < NUM_CFG; k++) begin
                if (wr_hot_s[k]) begin
                    cfg_r[k] <= rx_data_s;
                end
            end
            if (cs_fall_s) begin
                cpol_r <= cpol_s;
                cpha_r <= cpha_s;
            end
            if (!active_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
                if (cs_fall_s && !cpha_s) begin
                    miso_r <= 1'b0;
                end
            end else if (sample_s) begin
                rx_sr_r <= {rx_sr_r[FRAME_MAX-3:0], mosi_s};
                if (state_r == ST_CMD) begin
                    if (bit_cnt_r == CMD_LAST) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        addr_r    <= cmd_byte_s[6:0];
                        tx_sr_r   <= rd_val_s;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    end
                end else if (bit_cnt_r == DATA_LAST) begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                    addr_r    <= addr_inc_s;
                    if (state_r == ST_RDATA) begin
                        tx_sr_r <= rd_val_s;
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
            end else if (shift_s) begin
                if (state_r == ST_RDATA) begin
                    miso_r  <= tx_sr_r[REG_WIDTH-1];
                    tx_sr_r <= {tx_sr_r[REG_WIDTH-2:0], 1'b0};
                end else begin
                    miso_r <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
        assign config_regs[k*REG_WIDTH +: REG_WIDTH] = cfg_r[k];
    end

    assign spi_miso      = miso_r;
    assign spi_miso_oe   = ~cs_s;
    assign cfg_wr_strobe = strobe_r;
    assign busy          = (state_r != ST_IDLE);

endmodule
